// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe: two-stage normalizer between the mul/div cores and rounding.
// S1 captures the beat and its leading-zero count; S2 shifts, adjusts and flags.
module fp_norm_pipe #(
  parameter int MANT_IN_W  = 48,
  parameter int MANT_OUT_W = 26,
  parameter int EXP_IN_W   = 10,
  parameter int EXP_OUT_W  = 8,
  parameter int LZ_W       = $clog2(MANT_IN_W + 1)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sel,
  input  logic [MANT_IN_W-1:0]  mant_in,
  input  logic [EXP_IN_W-1:0]   exp_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MANT_OUT_W-1:0] mant_out,
  output logic [EXP_OUT_W-1:0]  exp_out,
  output logic [LZ_W-1:0]       lz_out,
  output logic                  sticky,
  output logic                  zero,
  output logic                  ovf,
  output logic                  unf
);

  localparam int EW = EXP_IN_W + 2;
  localparam int SW = MANT_IN_W - MANT_OUT_W;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_OUT_W) - 1);

  logic                        w_adv1;
  logic                        w_adv2;
  logic [LZ_W-1:0]             w_lz_div;
  logic [LZ_W-1:0]             w_lz;

  logic                        r_s1_valid;
  logic [MANT_IN_W-1:0]        r_s1_mant;
  logic signed [EXP_IN_W-1:0]  r_s1_exp;
  logic [LZ_W-1:0]             r_s1_lz;

  logic [LZ_W:0]               w_sh_amt;
  logic [MANT_IN_W-1:0]        w_shf;
  logic                        w_zero;
  logic signed [EW-1:0]        w_exp_x;
  logic signed [EW-1:0]        w_lz_x;
  logic signed [EW-1:0]        w_e;
  logic                        w_is_ovf;
  logic                        w_is_unf;

  logic [MANT_OUT_W-1:0]       w_n_mant;
  logic [EXP_OUT_W-1:0]        w_n_exp;
  logic [LZ_W-1:0]             w_n_lz;
  logic                        w_n_st;
  logic                        w_n_zero;
  logic                        w_n_ovf;
  logic                        w_n_unf;

  logic                        r_s2_valid;
  logic [MANT_OUT_W-1:0]       r_mant;
  logic [EXP_OUT_W-1:0]        r_exp;
  logic [LZ_W-1:0]             r_lz;
  logic                        r_st;
  logic                        r_zero;
  logic                        r_ovf;
  logic                        r_unf;

  assign w_adv2   = !r_s2_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1 && !arst;

  // Highest set bit wins, so the last match of the upward scan is kept.
  always_comb begin
    w_lz_div = LZ_W'(MANT_IN_W);
    for (int i = 0; i < MANT_IN_W; i++) begin
      if (mant_in[i]) w_lz_div = LZ_W'(MANT_IN_W - 1 - i);
    end
  end

  assign w_lz = sel ? w_lz_div
                    : (mant_in[MANT_IN_W-1] ? '0 : LZ_W'(1));

  always_ff @(posedge clk) begin
    if (arst) begin
      r_s1_valid <= 1'b0;
      r_s1_mant  <= '0;
      r_s1_exp   <= '0;
      r_s1_lz    <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mant <= mant_in;
        r_s1_exp  <= exp_in;
        r_s1_lz   <= w_lz;
      end
    end
  end

  // Shifting by lz+1 drops the leading one and lines the window up at the MSB.
  assign w_sh_amt = {1'b0, r_s1_lz} + (LZ_W + 1)'(1);
  assign w_shf    = r_s1_mant << w_sh_amt;
  assign w_zero   = ~|r_s1_mant;

  assign w_exp_x  = EW'(r_s1_exp);
  assign w_lz_x   = EW'({1'b0, r_s1_lz});
  assign w_e      = w_exp_x + EW'(1) - w_lz_x;
  assign w_is_ovf = !w_zero && (w_e >= EMAX);
  assign w_is_unf = !w_zero && (w_e <= EW'(0));

  always_comb begin
    w_n_mant = w_shf[MANT_IN_W-1 -: MANT_OUT_W];
    w_n_exp  = w_e[EXP_OUT_W-1:0];
    w_n_lz   = r_s1_lz;
    w_n_st   = |w_shf[SW-1:0];
    w_n_zero = 1'b0;
    w_n_ovf  = 1'b0;
    w_n_unf  = 1'b0;
    unique case (1'b1)
      w_zero: begin
        w_n_mant = '0;
        w_n_exp  = '0;
        w_n_st   = 1'b0;
        w_n_lz   = LZ_W'(MANT_IN_W);
        w_n_zero = 1'b1;
      end
      w_is_ovf: begin
        w_n_mant = '0;
        w_n_exp  = '1;
        w_n_st   = 1'b0;
        w_n_ovf  = 1'b1;
      end
      w_is_unf: begin
        w_n_mant = '0;
        w_n_exp  = '0;
        w_n_st   = 1'b0;
        w_n_unf  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_s2_valid <= 1'b0;
      r_mant     <= '0;
      r_exp      <= '0;
      r_lz       <= '0;
      r_st       <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_mant <= w_n_mant;
        r_exp  <= w_n_exp;
        r_lz   <= w_n_lz;
        r_st   <= w_n_st;
        r_zero <= w_n_zero;
        r_ovf  <= w_n_ovf;
        r_unf  <= w_n_unf;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign mant_out  = r_mant;
  assign exp_out   = r_exp;
  assign lz_out    = r_lz;
  assign sticky    = r_st;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb_fp_norm_pipe: vector table plus scoreboard for fp_norm_pipe.
// Covers mul/div normalization, exception edges, backpressure and reset.
module tb_fp_norm_pipe;

  localparam int MIW = 48;
  localparam int MOW = 26;
  localparam int EIW = 10;
  localparam int EOW = 8;
  localparam int LZW = 6;
  localparam int NV  = 18;

  logic           clk = 1'b0;
  logic           arst;
  logic           in_valid;
  logic           in_ready;
  logic           sel;
  logic [MIW-1:0] mant_in;
  logic [EIW-1:0] exp_in;
  logic           out_valid;
  logic           out_ready;
  logic [MOW-1:0] mant_out;
  logic [EOW-1:0] exp_out;
  logic [LZW-1:0] lz_out;
  logic           sticky;
  logic           zero;
  logic           ovf;
  logic           unf;

  fp_norm_pipe dut (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mant_in   (mant_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .exp_out   (exp_out),
    .lz_out    (lz_out),
    .sticky    (sticky),
    .zero      (zero),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic           sel;
    logic [MIW-1:0] mant;
    logic [EIW-1:0] ex;
    logic [MOW-1:0] m_o;
    logic [EOW-1:0] e_o;
    logic [LZW-1:0] lz;
    logic           st;
    logic           z;
    logic           ov;
    logic           un;
  } vec_t;

  typedef struct {
    int idx;
    int acc;
  } sb_t;

  vec_t vt[NV];
  sb_t  sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cur_idx = 0;
  bit   chk_lat = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {19'd0, out_valid, mant_out, exp_out, lz_out,
            sticky, zero, ovf, unf};
  endfunction

  task automatic apply(int idx);
    sel     = vt[idx].sel;
    mant_in = vt[idx].mant;
    exp_in  = vt[idx].ex;
    cur_idx = idx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    sb_t  e;
    vec_t v;
    forever begin
      @(negedge clk);
      if (arst) begin
        sbq.delete();
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got beat with empty scoreboard");
          end else begin
            e = sbq.pop_front();
            v = vt[e.idx];
            chk($sformatf("v%0d.mant", e.idx), 64'(mant_out), 64'(v.m_o));
            chk($sformatf("v%0d.exp", e.idx), 64'(exp_out), 64'(v.e_o));
            chk($sformatf("v%0d.lz", e.idx), 64'(lz_out), 64'(v.lz));
            chk($sformatf("v%0d.flags", e.idx),
                64'({sticky, zero, ovf, unf}),
                64'({v.st, v.z, v.ov, v.un}));
            if (chk_lat)
              chk($sformatf("v%0d.latency", e.idx), 64'(cyc - e.acc), 64'd2);
          end
        end
        if (in_valid && in_ready) sbq.push_back('{cur_idx, cyc});
      end
    end
  endtask

  task automatic send(int idx);
    int n;
    n = 0;
    in_valid = 1'b1;
    apply(idx);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept%0d", idx), 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
    step();
  endtask

  task automatic backpressure();
    int          sent;
    int          stall;
    int          first_block;
    bit          seen;
    logic [63:0] snap;
    sent = 0;
    stall = 0;
    first_block = -1;
    seen = 1'b0;
    snap = '0;
    chk_lat = 1'b0;
    for (int c = 0; c < 40 && (sent < 6 || sbq.size() != 0); c++) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        stall = 4;
      end
      out_ready = (stall == 0);
      in_valid = (sent < 6);
      if (sent < 6) apply(sent);
      @(negedge clk);
      if (stall == 4) snap = outs();
      else if (stall > 0) chk("bp_stable", outs(), snap);
      if (stall > 0) chk("bp_in_ready", 64'(in_ready), 64'd0);
      if (in_valid && !in_ready && first_block < 0) first_block = sent;
      if (in_valid && in_ready) sent++;
      if (stall > 0) stall--;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_block_depth", 64'(first_block), 64'd2);
    chk("bp_all_sent", 64'(sent), 64'd6);
    chk("bp_drained", 64'(sbq.size()), 64'd0);
  endtask

  task automatic reset_mid();
    chk_lat = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    apply(9);
    repeat (3) step();
    @(negedge clk);
    chk("rm_full_out_valid", 64'(out_valid), 64'd1);
    chk("rm_full_in_ready", 64'(in_ready), 64'd0);
    step();
    arst = 1'b1;
    in_valid = 1'b0;
    step();
    arst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rm_outs_zero", outs(), 64'd0);
    chk("rm_in_ready", 64'(in_ready), 64'd1);
    step();
    chk_lat = 1'b1;
    send(11);
    drain();
  endtask

  initial begin
    int t0;
    vt[0]  = '{1'b0, 48'hC000_0000_0000, 10'd127, 26'h200_0000, 8'h80, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 48'h4000_0000_0001, 10'd127, 26'h000_0000, 8'h7F, 6'd1,  1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 48'h0000_0010_0000, 10'd150, 26'h000_0000, 8'h7C, 6'd27, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 48'h0000_0010_0000, 10'd20,  26'h000_0000, 8'h00, 6'd27, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 48'h0000_0000_0000, 10'd500, 26'h000_0000, 8'h00, 6'd48, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 48'h8000_0000_0000, 10'd254, 26'h000_0000, 8'hFF, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 48'h8000_0000_0000, 10'd253, 26'h000_0000, 8'hFE, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 48'h8000_0000_0000, 10'h3FF, 26'h000_0000, 8'h00, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 48'h8000_0000_0000, 10'd0,   26'h000_0000, 8'h01, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 48'hFFFF_FFFF_FFFF, 10'd10,  26'h3FF_FFFF, 8'd11, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 48'h0000_0000_0003, 10'd60,  26'h200_0000, 8'd15, 6'd46, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 48'h0123_4567_89AB, 10'd200, 26'h08D_159E, 8'hC2, 6'd7,  1'b1, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 48'h2000_0000_0000, 10'd50,  26'h200_0000, 8'd50, 6'd1,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b0, 48'h0000_0000_0000, 10'd5,   26'h000_0000, 8'h00, 6'd48, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[14] = '{1'b1, 48'h0000_0000_0001, 10'd100, 26'h000_0000, 8'd54, 6'd47, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b1, 48'h8000_0000_0000, 10'd300, 26'h000_0000, 8'hFF, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[16] = '{1'b1, 48'h0000_0000_0001, 10'h200, 26'h000_0000, 8'h00, 6'd47, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[17] = '{1'b0, 48'h0000_0000_0001, 10'd40,  26'h000_0000, 8'd40, 6'd1,  1'b1, 1'b0, 1'b0, 1'b0};

    arst = 1'b1;
    in_valid = 1'b0;
    sel = 1'b0;
    mant_in = '0;
    exp_in = '0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_outs_zero", outs(), 64'd0);
    @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    step();

    chk_lat = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(i);
      drain();
    end

    t0 = cyc;
    for (int i = 0; i < NV; i++) send(i);
    chk("b2b_cycles", 64'(cyc - t0), 64'(NV));
    drain();

    backpressure();
    reset_mid();

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_norm_pipe.md
# fp_norm_pipe

Parametrised, two-stage pipelined normalizer for the FP multiply/divide datapath. It takes the raw product or quotient mantissa and the pre-adjusted exponent, and finds the leading one: the top two bits in multiply mode, a full leading-zero search in divide mode. It then emits the hidden-bit-stripped mantissa, the adjusted exponent, a sticky bit and exception flags. It sits between the multiplier/divider cores and the rounding/packing stage, with valid/ready flow control on both sides.

## Interface
- MANT_IN_W, 48: raw mantissa width; ≥ MANT_OUT_W+1.
- MANT_OUT_W, 26: output mantissa width; hidden bit excluded.
- EXP_IN_W, 10: input exponent width, two's complement.
- EXP_OUT_W, 8: output biased exponent width.
- LZ_W, $clog2(MANT_IN_W+1): leading-zero count width (derived).

- clk  in  1  clock, rising edge.
- arst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- sel  in  1  0 = multiply, 1 = divide.
- mant_in  in  MANT_IN_W  raw mantissa.
- exp_in  in  EXP_IN_W  exponent from exponent logic.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- mant_out  out  MANT_OUT_W  normalized mantissa.
- exp_out  out  EXP_OUT_W  adjusted exponent.
- lz_out  out  LZ_W  applied leading-zero count.
- sticky  out  1  OR of all mantissa bits below the mant_out window.
- zero  out  1  mant_in was all zeros.
- ovf  out  1  exponent overflow.
- unf  out  1  exponent underflow.

## Operation
- **Stage 1** (S1) registers sel, mant_in and exp_in, and computes lz:
  - multiply: lz = 0 if mant_in[MSB] = 1, else 1; no deeper search.
  - divide: lz = number of leading zeros, 0..MANT_IN_W.
- **Stage 2** (S2) shifts and adjusts:
  - mant_out = bits [MSB-1-lz -: MANT_OUT_W] of mant_in. Missing low bits are zero-filled.
  - sticky = OR of mant_in bits below the window.
  - e = exp_in + 1 − lz, computed signed at EXP_IN_W+2 bits.
- **Exception priority: zero > ovf > unf > normal.**
  - zero: mant_out = 0, exp_out = 0, sticky = 0, lz_out = MANT_IN_W; ovf = unf = 0.
  - ovf when e ≥ 2^EXP_OUT_W − 1: exp_out = all ones, mant_out = 0, sticky = 0.
  - unf when e ≤ 0: flush to zero, exp_out = 0, mant_out = 0, sticky = 0.
  - normal: exp_out = e[EXP_OUT_W-1:0].
- Flags are mutually exclusive and are valid only with out_valid.

## Timing
- Latency is 2 cycles: a beat accepted at edge N is presented with out_valid = 1 after edge N+2, provided there is no backpressure.
- Throughput is 1 beat/cycle while out_ready = 1.
- Stage advance conditions:
  - adv2 = !s2_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1 & !arst
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- While out_valid = 1 and out_ready = 0, all outputs hold stable and S1 holds if it is full. No beat is dropped or duplicated.
- A simultaneous input and output transfer with both stages full is legal and keeps the pipe full.
- While arst = 1 at an edge:
  - s1_valid = s2_valid = 0.
  - out_valid = 0; mant_out, exp_out, lz_out, sticky, zero, ovf and unf all = 0.
  - in_ready = 0 during reset and 1 in the first cycle after it.
- Reset mid-operation discards both in-flight beats.
- The data path outputs only change on an S2 load.

## Test plan
- **Multiply, MSB set.** sel=0, mant_in=48'hC000_0000_0000, exp_in=127 → exp_out=128, mant_out=26'h200_0000, lz_out=0, sticky=0, output 2 cycles later.
- **Multiply, MSB clear.** sel=0, mant_in=48'h4000_0000_0001, exp_in=127 → exp_out=127, mant_out=0, lz_out=1, sticky=1.
- **Divide, deep shift and underflow.**
  - sel=1, mant_in=48'h0000_0010_0000, exp_in=150 → lz_out=27, exp_out=124, mant_out=0, sticky=0.
  - Same mant_in with exp_in=20 → unf=1, exp_out=0, mant_out=0.
- **Zero and overflow.**
  - sel=1, mant_in=0 → zero=1, lz_out=48, exp_out=0, ovf=unf=0.
  - sel=0, mant_in=48'h8000_0000_0000, exp_in=254 → ovf=1, exp_out=8'hFF, mant_out=0.
- **Backpressure.** Stream 6 beats back-to-back and hold out_ready=0 for 4 cycles from the first out_valid → in_ready drops after 2 beats are buffered, outputs stay stable, and all 6 results emerge in order with none lost.
- **Reset mid-stream.** Assert arst for 1 cycle with both stages full → next cycle out_valid=0 and all outputs 0; the next accepted beat emerges exactly 2 cycles after its acceptance.
